io_event_capture: RTL

- Synthesizable successor to the simulation-only result/IO monitor wrapped around the Reduceron core.
- Watches the core's IO write port, the GC state bit, the heap pointer and the finish strobe, and timestamps each occurrence.
- Buffers occurrences as typed event records in a FIFO and drains them over a valid/ready stream to a host link (UART/JTAG bridge).
- Terminates with a single finish record carrying the decoded result value and tag.

---
 rtl/reduceron_io_pkg.sv | 24 ++
 rtl/event_fifo.sv | 53 +++++
 rtl/io_event_capture.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/reduceron_io_pkg.sv
// Event-kind codes, capture FSM states and record-width helper shared by the capture block.
// No logic; constants and types only.
// Backpressure: n/a.
package reduceron_io_pkg;

    localparam logic [2:0] EV_IO       = 3'd0;
    localparam logic [2:0] EV_GC_START = 3'd1;
    localparam logic [2:0] EV_GC_END   = 3'd2;
    localparam logic [2:0] EV_HEAP     = 3'd3;
    localparam logic [2:0] EV_FINISH   = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_FINAL,
        ST_DONE
    } state_t;

    // Record layout, MSB first: kind[2:0], cycle, payload, aux.
    function automatic int rec_w(input int cyc_w, input int pay_w, input int aux_w);
        return 3 + cyc_w + pay_w + aux_w;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous FIFO with full/empty flags; push and pop may share a cycle even when full.
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: push while full (without pop) and pop while empty are ignored.
module event_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign head_dat = mem[rd_ptr];
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/io_event_capture.sv
// Timestamps core IO/GC (and heap, with HEAP_TRACE_EN) events into a FIFO, ends with a finish record.
// Latency: an event is presented on ev_valid one cycle after it is sampled.
// Backpressure: ev_ready stalls the FIFO; full FIFO drops IO, GC edges wait in a one-entry slot.
module io_event_capture
    import reduceron_io_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 14,
    parameter int RES_W  = 17,
    parameter int TAG_W  = 3,
    parameter int HEAP_W = 14,
    parameter int CYC_W  = 24,
    parameter int PAY_W  = 24,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iowrite,
    input  logic [ADDR_W-1:0] ioaddr,
    input  logic [DATA_W-1:0] iowd,
    input  logic [RES_W-1:0]  result,
    input  logic              gc,
    input  logic [HEAP_W-1:0] heap,
    input  logic              finish,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [2:0]        ev_kind,
    output logic [CYC_W-1:0]  ev_cycle,
    output logic [PAY_W-1:0]  ev_payload,
    output logic [ADDR_W-1:0] ev_aux,
    output logic [15:0]       drop_cnt,
    output logic              done
);
    typedef struct packed {
        logic [2:0]        kind;
        logic [CYC_W-1:0]  cyc;
        logic [PAY_W-1:0]  pay;
        logic [ADDR_W-1:0] aux;
    } rec_t;

    localparam int REC_W = rec_w(CYC_W, PAY_W, ADDR_W);

    state_t            state;
    logic [CYC_W-1:0]  cyc, gc_dur, fin_cyc;
    logic              gc_q, pend_vld, done_q;
    logic [RES_W-1:0]  res_q;
    logic [15:0]       drop_q;
    rec_t              pend_rec, io_rec, gc_rec, push_rec, head_rec, fin_rec, out_rec;
    logic [REC_W-1:0]  push_dat, head_dat;
    logic              run, io_ev, gc_ev, push, pop, can_push;
    logic              fifo_full, fifo_empty, pend_push, pend_load;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;

    assign run      = (state == ST_RUN);
    assign io_ev    = run & iowrite;
    assign gc_ev    = run & (gc ^ gc_q);
    assign pop      = ev_ready & ~fifo_empty;
    assign can_push = ~fifo_full | pop;
    assign drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};

    assign io_rec  = '{kind: EV_IO, cyc: cyc, pay: PAY_W'(iowd), aux: ioaddr};
    assign gc_rec  = '{kind: gc ? EV_GC_START : EV_GC_END, cyc: cyc,
                       pay: gc ? '0 : PAY_W'(gc_dur), aux: '0};
    assign fin_rec = '{kind: EV_FINISH, cyc: fin_cyc, pay: PAY_W'(res_q >> TAG_W),
                       aux: ADDR_W'(res_q[TAG_W-1:0])};

`ifdef HEAP_TRACE_EN
    logic [HEAP_W-1:0] last_heap;
    logic              heap_ev, heap_push;
    rec_t              heap_rec;

    assign heap_ev  = run & (heap != last_heap);
    assign heap_rec = '{kind: EV_HEAP, cyc: cyc, pay: PAY_W'(heap), aux: '0};

    // Only the value at push time is recorded, so intermediate changes coalesce.
    always_ff @(posedge clock) begin
        if (reset)          last_heap <= '0;
        else if (heap_push) last_heap <= heap;
    end
`else
    logic unused_heap;
    assign unused_heap = ^heap;
`endif

    // One push per cycle: IO, then the pending GC slot, then a fresh GC edge, then heap.
    always_comb begin
        push      = 1'b0;
        push_rec  = io_rec;
        pend_push = 1'b0;
        pend_load = 1'b0;
        drop_inc  = 2'd0;
`ifdef HEAP_TRACE_EN
        heap_push = 1'b0;
`endif
        if (io_ev) begin
            if (can_push) push = 1'b1;
            else          drop_inc = drop_inc + 2'd1;
            if (gc_ev) begin
                if (pend_vld) drop_inc = drop_inc + 2'd1;
                else          pend_load = 1'b1;
            end
        end else if (pend_vld) begin
            if (can_push) begin
                push      = 1'b1;
                push_rec  = pend_rec;
                pend_push = 1'b1;
            end
            if (gc_ev) drop_inc = drop_inc + 2'd1;
        end else if (gc_ev) begin
            if (can_push) begin
                push     = 1'b1;
                push_rec = gc_rec;
            end else begin
                pend_load = 1'b1;
            end
        end
`ifdef HEAP_TRACE_EN
        else if (heap_ev && can_push) begin
            push      = 1'b1;
            push_rec  = heap_rec;
            heap_push = 1'b1;
        end
`endif
    end

    assign push_dat = push_rec;
    assign head_rec = head_dat;

    event_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_RUN;
            cyc      <= '0;
            gc_dur   <= '0;
            gc_q     <= 1'b0;
            pend_vld <= 1'b0;
            pend_rec <= '0;
            drop_q   <= '0;
            res_q    <= '0;
            fin_cyc  <= '0;
            done_q   <= 1'b0;
        end else begin
            gc_q <= gc;
            if (state != ST_DONE && cyc != '1) cyc <= cyc + CYC_W'(1);
            // Counts the rising-edge cycle itself, so a 10-cycle window reports 10.
            if (gc && !gc_q)                gc_dur <= CYC_W'(1);
            else if (gc && gc_dur != '1)    gc_dur <= gc_dur + CYC_W'(1);
            if (pend_load) begin
                pend_vld <= 1'b1;
                pend_rec <= gc_rec;
            end else if (pend_push) begin
                pend_vld <= 1'b0;
            end
            drop_q <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
            case (state)
                ST_RUN: if (finish) begin
                    state   <= ST_DRAIN;
                    res_q   <= result;
                    fin_cyc <= cyc;
                end
                ST_DRAIN: if (fifo_empty && !pend_vld) state <= ST_FINAL;
                ST_FINAL: if (ev_ready) begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end
                default: state <= ST_DONE;
            endcase
        end
    end

    always_comb begin
        out_rec = '0;
        if (state == ST_FINAL)  out_rec = fin_rec;
        else if (!fifo_empty)   out_rec = head_rec;
    end

    assign ev_valid   = ~fifo_empty | (state == ST_FINAL);
    assign ev_kind    = out_rec.kind;
    assign ev_cycle   = out_rec.cyc;
    assign ev_payload = out_rec.pay;
    assign ev_aux     = out_rec.aux;
    assign drop_cnt   = drop_q;
    assign done       = done_q;

endmodule
